// File: rtl/sp_peer_pkg.sv
// Shared constants for the sp_peer serial-port far-end device.
package sp_peer_pkg;

    localparam int   BITS_PER_BYTE = 8;
    localparam logic LINE_IDLE     = 1'b1;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_LOW  = 2'd1;
    localparam logic [1:0] T_HIGH = 2'd2;

endpackage

// File: rtl/sp_peer_sync.sv
// Two-flop synchronizer; resets to the serial line idle level so no false CNT edge follows reset.
module sp_peer_sync
    import sp_peer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sp_peer.sv
// Far-end peer for the CIA-style serial port: RX deserializer, TX serializer with CNT generation.
// Define SP_PEER_FLAG_EN to enable the flag_n pulse per received byte.
module sp_peer
    import sp_peer_pkg::*;
#(
    parameter int CNT_DIV     = 8,
    parameter int RX_TIMEOUT  = 1024,
    parameter int FLAG_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cnt_out,
    input  logic       sp_out,
    output logic       cnt_in,
    output logic       sp_in,
    output logic       flag_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_timeout
);

    localparam int DIV_W  = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);

    logic cnt_s;
    logic sp_s;

    sp_peer_sync u_sync_cnt (.clk(clk), .reset(reset), .d_i(cnt_out), .q_o(cnt_s));
    sp_peer_sync u_sync_sp  (.clk(clk), .reset(reset), .d_i(sp_out),  .q_o(sp_s));

    logic              cnt_prev_q;
    logic              rise_q;
    logic              sp_dly_q;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_timeout_q, rx_timeout_d;
    logic              byte_done;

    // The rise is registered together with SP so both stay aligned one cycle after the synchronizer.
    assign byte_done = rise_q && (bitcnt_q == 3'(BITS_PER_BYTE - 1));

    always_comb begin
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        idle_d       = idle_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_timeout_d = 1'b0;
        if (rise_q) begin
            shift_d  = {shift_q[6:0], sp_dly_q};
            bitcnt_d = bitcnt_q + 3'd1;
            idle_d   = '0;
            if (byte_done) begin
                rx_data_d  = {shift_q[6:0], sp_dly_q};
                rx_valid_d = 1'b1;
            end
        end else if (bitcnt_q != 3'd0) begin
            if (idle_q == IDLE_W'(RX_TIMEOUT)) begin
                bitcnt_d     = 3'd0;
                idle_d       = '0;
                rx_timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_prev_q   <= LINE_IDLE;
            rise_q       <= 1'b0;
            sp_dly_q     <= LINE_IDLE;
            bitcnt_q     <= 3'd0;
            idle_q       <= '0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_timeout_q <= 1'b0;
        end else begin
            cnt_prev_q   <= cnt_s;
            rise_q       <= cnt_s & ~cnt_prev_q;
            sp_dly_q     <= sp_s;
            bitcnt_q     <= bitcnt_d;
            idle_q       <= idle_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

    // Partial-byte contents are meaningless once bit count is cleared, so the shifter needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_timeout = rx_timeout_q;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       idx_dec;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       data_q, data_d;
    logic             sp_q, sp_d;
    logic             div_last;

    assign idx_dec  = idx_q - 3'd1;
    assign div_last = (div_q == DIV_W'(CNT_DIV - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        div_d   = div_q;
        data_d  = data_q;
        sp_d    = sp_q;
        case (state_q)
            T_IDLE: begin
                if (tx_valid) begin
                    data_d  = tx_data;
                    idx_d   = 3'(BITS_PER_BYTE - 1);
                    div_d   = '0;
                    sp_d    = tx_data[7];
                    state_d = T_LOW;
                end
            end
            T_LOW: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = T_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            T_HIGH: begin
                if (div_last) begin
                    div_d = '0;
                    if (idx_q != 3'd0) begin
                        idx_d   = idx_dec;
                        sp_d    = data_q[idx_dec];
                        state_d = T_LOW;
                    end else begin
                        sp_d    = LINE_IDLE;
                        state_d = T_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                sp_d    = LINE_IDLE;
                state_d = T_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T_IDLE;
            idx_q   <= 3'd0;
            div_q   <= '0;
            sp_q    <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            sp_q    <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign cnt_in   = (state_q != T_LOW);
    assign sp_in    = sp_q;
    assign tx_ready = (state_q == T_IDLE);

`ifdef SP_PEER_FLAG_EN
    localparam int FLAG_W = $clog2(FLAG_CYCLES + 1);

    logic [FLAG_W-1:0] flag_cnt_q, flag_cnt_d;

    // Loaded on the same edge that raises rx_valid, so the low pulse lines up with it.
    always_comb begin
        flag_cnt_d = flag_cnt_q;
        if (byte_done) begin
            flag_cnt_d = FLAG_W'(FLAG_CYCLES);
        end else if (flag_cnt_q != '0) begin
            flag_cnt_d = flag_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_cnt_q <= '0;
        end else begin
            flag_cnt_q <= flag_cnt_d;
        end
    end

    assign flag_n = (flag_cnt_q == '0);
`else
    logic flag_cycles_unused;
    assign flag_cycles_unused = (FLAG_CYCLES > 0);
    assign flag_n             = 1'b1;
`endif

endmodule

// File: tb/tb_sp_peer.sv
// Directed bench for sp_peer: vector table of full-duplex transfers plus timeout, back-to-back and reset sequences.
module tb_sp_peer;

`ifdef SP_PEER_FLAG_EN
    localparam int EXP_FLAG = 4;
`else
    localparam int EXP_FLAG = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cnt_out = 1'b1;
    logic       sp_out = 1'b1;
    logic       cnt_in;
    logic       sp_in;
    logic       flag_n;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_timeout;

    sp_peer #(.CNT_DIV(8), .RX_TIMEOUT(1024), .FLAG_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .cnt_out(cnt_out), .sp_out(sp_out),
        .cnt_in(cnt_in), .sp_in(sp_in), .flag_n(flag_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_rxv = 0, n_tmo = 0, n_flag = 0, low_len = 0, bad_low = 0;
    always @(negedge clk) begin
        if (rx_valid) n_rxv++;
        if (rx_timeout) n_tmo++;
        if (!flag_n) n_flag++;
        if (!cnt_in) low_len++;
        else if (low_len != 0) begin
            if (low_len != 8) bad_low++;
            low_len = 0;
        end
    end

    // SoC-side receiver: samples sp_in on every rising cnt_in.
    logic [15:0] soc_sr = 16'h0;
    int soc_rises = 0;
    always @(posedge cnt_in) begin
        soc_sr = {soc_sr[14:0], sp_in};
        soc_rises++;
    end

    int nvec = 0, nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic soc_send(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            cnt_out = 1'b0;
            sp_out  = b[i];
            repeat (16) @(negedge clk);
            cnt_out = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic peer_send(input logic [7:0] b, output int lat);
        int n = 0;
        int a;
        while (!tx_ready && n < 400) begin @(negedge clk); n++; end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        a = cyc;
        check("tx_ready_drop", tx_ready, 0);
        n = 0;
        while (!tx_ready && n < 400) begin @(negedge clk); n++; end
        lat = cyc - a;
    endtask

    typedef struct {
        logic [7:0] soc;
        logic [7:0] peer;
        logic [7:0] exp_rx;
        logic [7:0] exp_soc;
    } vec_t;

    vec_t vecs[5];
    int lat, lat2;
    int r0, t0, f0, s0, b0, a0, n;

    initial begin
        vecs[0] = '{soc: 8'hA5, peer: 8'h3C, exp_rx: 8'hA5, exp_soc: 8'h3C};
        vecs[1] = '{soc: 8'h0F, peer: 8'hF0, exp_rx: 8'h0F, exp_soc: 8'hF0};
        vecs[2] = '{soc: 8'h81, peer: 8'h00, exp_rx: 8'h81, exp_soc: 8'h00};
        vecs[3] = '{soc: 8'h00, peer: 8'hFF, exp_rx: 8'h00, exp_soc: 8'hFF};
        vecs[4] = '{soc: 8'hFF, peer: 8'h55, exp_rx: 8'hFF, exp_soc: 8'h55};

        repeat (3) @(negedge clk);
        check("rst_cnt_in", cnt_in, 1);
        check("rst_sp_in", sp_in, 1);
        check("rst_flag_n", flag_n, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_timeout", rx_timeout, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            r0 = n_rxv; t0 = n_tmo; f0 = n_flag; s0 = soc_rises; b0 = bad_low;
            fork
                soc_send(vecs[v].soc, 8);
                peer_send(vecs[v].peer, lat);
            join
            repeat (12) @(negedge clk);
            check("vec_rx_data", rx_data, vecs[v].exp_rx);
            check("vec_soc_rx", soc_sr[7:0], vecs[v].exp_soc);
            check("vec_rx_valid_cnt", n_rxv - r0, 1);
            check("vec_timeout_cnt", n_tmo - t0, 0);
            check("vec_flag_low", n_flag - f0, EXP_FLAG);
            check("vec_cnt_rises", soc_rises - s0, 8);
            check("vec_low_width", bad_low - b0, 0);
            check("vec_tx_latency", lat, 128);
        end

        // Timeout: 5 bits then silence; partial byte dropped, rx_data kept.
        r0 = n_rxv; t0 = n_tmo;
        soc_send(8'hB3, 5);
        repeat (1100) @(negedge clk);
        check("tmo_pulse_cnt", n_tmo - t0, 1);
        check("tmo_no_valid", n_rxv - r0, 0);
        check("tmo_rx_data_kept", rx_data, 8'hFF);
        r0 = n_rxv; t0 = n_tmo;
        soc_send(8'h81, 8);
        repeat (12) @(negedge clk);
        check("tmo_next_byte", rx_data, 8'h81);
        check("tmo_next_valid", n_rxv - r0, 1);
        check("tmo_next_no_tmo", n_tmo - t0, 0);

        // Back-to-back: tx_valid held across two bytes.
        s0 = soc_rises; b0 = bad_low;
        tx_data = 8'h01; tx_valid = 1'b1;
        @(negedge clk);
        a0 = cyc;
        tx_data = 8'hFF;
        n = 0;
        while (!tx_ready && n < 400) begin @(negedge clk); n++; end
        check("b2b_first_latency", cyc - a0, 128);
        @(negedge clk);
        check("b2b_gap_one_cycle", tx_ready, 0);
        tx_valid = 1'b0;
        n = 0;
        while (!tx_ready && n < 400) begin @(negedge clk); n++; end
        check("b2b_total_latency", cyc - a0, 257);
        check("b2b_soc_rx", soc_sr, 16'h01FF);
        check("b2b_cnt_rises", soc_rises - s0, 16);
        check("b2b_low_width", bad_low - b0, 0);

        // Reset mid-TX, four bits into byte 0xAA.
        tx_data = 8'hAA; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (52) @(negedge clk);
        check("mid_tx_cnt_low", cnt_in, 0);
        #1 reset = 1'b1;
        #1;
        check("arst_cnt_in", cnt_in, 1);
        check("arst_sp_in", sp_in, 1);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_rx_data", rx_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        s0 = soc_rises; b0 = bad_low;
        peer_send(8'h55, lat2);
        repeat (4) @(negedge clk);
        check("post_rst_soc_rx", soc_sr[7:0], 8'h55);
        check("post_rst_rises", soc_rises - s0, 8);
        check("post_rst_latency", lat2, 128);
        check("post_rst_low_width", bad_low - b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
